// File: rtl/ext_int_ctrl.sv
// External interrupt controller: edge-latched, masked sources arbitrated onto the core's EIC request/ack port.
// Optional round-robin arbitration is enabled with `define EIC_ROUND_ROBIN_EN.
module ext_int_ctrl #(
  parameter int unsigned NUM_SRC = 4,
  parameter int unsigned ID_W    = 2
) (
  input  logic                Sys_Clock,
  input  logic                Sys_Reset,
  input  logic [NUM_SRC-1:0]  Irq_Src,
  input  logic                Cfg_EnW,
  input  logic                Cfg_EnR,
  input  logic [1:0]          Cfg_Addr,
  input  logic [31:0]         Cfg_DataW,
  output logic [31:0]         Cfg_DataR,
  output logic                EIC_I_Req,
  output logic [ID_W-1:0]     EIC_I_Id,
  input  logic                EIC_I_Ack
);

  localparam int unsigned ST_W = 2;
  localparam logic [ST_W-1:0] ST_IDLE    = 2'd0;
  localparam logic [ST_W-1:0] ST_REQ     = 2'd1;
  localparam logic [ST_W-1:0] ST_SERVICE = 2'd2;

  localparam logic [1:0] A_MASK    = 2'd0;
  localparam logic [1:0] A_PENDING = 2'd1;
  localparam logic [1:0] A_EOI     = 2'd2;
  localparam logic [1:0] A_STATUS  = 2'd3;

  logic [ST_W-1:0]    state, state_nxt;
  logic [NUM_SRC-1:0] src_d;
  logic [NUM_SRC-1:0] mask;
  logic [NUM_SRC-1:0] pending, pend_nxt;
  logic [NUM_SRC-1:0] eligible;
  logic [ID_W-1:0]    win;
  logic               grant;
  logic               ack_ok;
  logic               eoi_wr;
  logic [31:0]        rd_data;
  logic               cfg_unused;

  // Upper write-data bits beyond NUM_SRC are don't-care for every register.
  assign cfg_unused = ^Cfg_DataW;

  assign eligible = pending & mask;
  assign grant    = (state == ST_IDLE) && (|eligible);
  assign ack_ok   = (state == ST_REQ) && EIC_I_Ack;
  assign eoi_wr   = Cfg_EnW && (Cfg_Addr == A_EOI);

`ifdef EIC_ROUND_ROBIN_EN
  logic [ID_W-1:0] rr_ptr;
  logic            hi_found, lo_found;
  logic [ID_W-1:0] hi_win, lo_win;

  always_ff @(posedge Sys_Clock) begin
    if (Sys_Reset) begin
      rr_ptr <= '0;
    end else if (ack_ok) begin
      rr_ptr <= (EIC_I_Id == ID_W'(NUM_SRC - 1)) ? '0 : EIC_I_Id + 1'b1;
    end
  end

  // First eligible at or above the pointer, else wrap to the lowest eligible.
  always_comb begin
    hi_found = 1'b0;
    hi_win   = '0;
    lo_found = 1'b0;
    lo_win   = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (eligible[i] && (ID_W'(i) >= rr_ptr) && !hi_found) begin
        hi_found = 1'b1;
        hi_win   = ID_W'(i);
      end
      if (eligible[i] && !lo_found) begin
        lo_found = 1'b1;
        lo_win   = ID_W'(i);
      end
    end
    win = hi_found ? hi_win : lo_win;
  end
`else
  logic found;

  // Fixed priority: lowest eligible index wins.
  always_comb begin
    found = 1'b0;
    win   = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (eligible[i] && !found) begin
        found = 1'b1;
        win   = ID_W'(i);
      end
    end
  end
`endif

  // Clears first, then new rising edges so a coincident edge keeps the bit set.
  always_comb begin
    pend_nxt = pending;
    if (Cfg_EnW && (Cfg_Addr == A_PENDING)) begin
      pend_nxt = pend_nxt & ~Cfg_DataW[NUM_SRC-1:0];
    end
    for (int i = 0; i < NUM_SRC; i++) begin
      if (ack_ok && (EIC_I_Id == ID_W'(i))) begin
        pend_nxt[i] = 1'b0;
      end
    end
    pend_nxt = pend_nxt | (Irq_Src & ~src_d);
  end

  always_comb begin
    rd_data = '0;
    case (Cfg_Addr)
      A_MASK:    rd_data = 32'(mask);
      A_PENDING: rd_data = 32'(pending);
      A_EOI:     rd_data = '0;
      A_STATUS:  rd_data = 32'(state) | (32'(EIC_I_Id) << 8);
      default:   rd_data = '0;
    endcase
  end

  always_ff @(posedge Sys_Clock) begin
    if (Sys_Reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:    if (|eligible) state_nxt = ST_REQ;
      ST_REQ:     if (EIC_I_Ack) state_nxt = ST_SERVICE;
      ST_SERVICE: if (eoi_wr)    state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge Sys_Clock) begin
    if (Sys_Reset) begin
      src_d     <= '0;
      mask      <= '0;
      pending   <= '0;
      EIC_I_Req <= 1'b0;
      EIC_I_Id  <= '0;
      Cfg_DataR <= '0;
    end else begin
      src_d   <= Irq_Src;
      pending <= pend_nxt;
      if (Cfg_EnW && (Cfg_Addr == A_MASK)) begin
        mask <= Cfg_DataW[NUM_SRC-1:0];
      end
      if (grant) begin
        EIC_I_Req <= 1'b1;
        EIC_I_Id  <= win;
      end else if (ack_ok) begin
        EIC_I_Req <= 1'b0;
      end
      if (Cfg_EnR) begin
        Cfg_DataR <= rd_data;
      end
    end
  end

endmodule

// File: tb/tb_ext_int_ctrl.sv
// Bench for ext_int_ctrl: directed handshake/boundary steps then random traffic,
// every cycle compared against an integer-level reference model.
module tb_ext_int_ctrl;

  localparam int unsigned NUM_SRC = 4;
  localparam int unsigned ID_W    = 2;
  localparam int          SRC_MSK = (1 << NUM_SRC) - 1;

  logic               clk = 1'b0;
  logic               rst;
  logic [NUM_SRC-1:0] irq;
  logic               enw, enr;
  logic [1:0]         addr;
  logic [31:0]        dataw;
  logic [31:0]        datar;
  logic               req;
  logic [ID_W-1:0]    id;
  logic               ack;

  int vectors    = 0;
  int miscompares = 0;

  // Reference model state (plain integers).
  int m_mask, m_pend, m_srcd, m_state, m_req, m_id, m_datar, m_ptr;

  ext_int_ctrl #(.NUM_SRC(NUM_SRC), .ID_W(ID_W)) dut (
    .Sys_Clock (clk),
    .Sys_Reset (rst),
    .Irq_Src   (irq),
    .Cfg_EnW   (enw),
    .Cfg_EnR   (enr),
    .Cfg_Addr  (addr),
    .Cfg_DataW (dataw),
    .Cfg_DataR (datar),
    .EIC_I_Req (req),
    .EIC_I_Id  (id),
    .EIC_I_Ack (ack)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int pick_winner(input int elig);
    int idx;
    for (int k = 0; k < int'(NUM_SRC); k++) begin
`ifdef EIC_ROUND_ROBIN_EN
      idx = (m_ptr + k) % int'(NUM_SRC);
`else
      idx = k;
`endif
      if (((elig >> idx) & 1) != 0) return idx;
    end
    return 0;
  endfunction

  // Next-state of the model from the inputs presented before the coming edge.
  task automatic model_step();
    int rise, elig, npend, a, d;
    if (rst) begin
      m_mask = 0; m_pend = 0; m_srcd = 0; m_state = 0;
      m_req = 0; m_id = 0; m_datar = 0; m_ptr = 0;
      return;
    end
    a     = int'(addr);
    d     = int'(dataw);
    rise  = int'(irq) & ~m_srcd & SRC_MSK;
    elig  = m_pend & m_mask;
    if (enr) begin
      case (a)
        0:       m_datar = m_mask;
        1:       m_datar = m_pend;
        3:       m_datar = m_state + (m_id * 256);
        default: m_datar = 0;
      endcase
    end
    npend = m_pend;
    if (enw && a == 1) npend = npend & ~(d & SRC_MSK);
    if (m_state == 1 && ack) npend = npend & ~(1 << m_id);
    npend = npend | rise;
    case (m_state)
      0: if (elig != 0) begin m_state = 1; m_req = 1; m_id = pick_winner(elig); end
      1: if (ack) begin m_state = 2; m_req = 0; m_ptr = (m_id + 1) % int'(NUM_SRC); end
      default: if (enw && a == 2) m_state = 0;
    endcase
    if (enw && a == 0) m_mask = d & SRC_MSK;
    m_srcd = int'(irq);
    m_pend = npend;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check("req", 32'(req), 32'(m_req));
    check("id", 32'(id), 32'(m_id));
    check("datar", datar, 32'(m_datar));
  endtask

  task automatic cfg_write(input logic [1:0] a, input logic [31:0] d);
    enw = 1'b1; addr = a; dataw = d;
    tick();
    enw = 1'b0;
  endtask

  task automatic cfg_read(input logic [1:0] a, output logic [31:0] d);
    enr = 1'b1; addr = a;
    tick();
    enr = 1'b0;
    d = datar;
  endtask

  task automatic pulse(input logic [NUM_SRC-1:0] b);
    irq = b;
    tick();
    irq = '0;
    tick();
  endtask

  task automatic ack_tick();
    ack = 1'b1;
    tick();
    ack = 1'b0;
  endtask

  logic [31:0] rd;

  initial begin
    rst = 1'b1; irq = '0; enw = 1'b0; enr = 1'b0; addr = '0; dataw = '0; ack = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    check("rst_req", 32'(req), 32'd0);
    check("rst_id", 32'(id), 32'd0);
    check("rst_datar", datar, 32'd0);

    // Single source request/ack/EOI.
    cfg_write(2'd0, 32'hF);
    irq = 4'b0100;
    tick();
    check("s1_no_req_yet", 32'(req), 32'd0);
    irq = '0;
    tick();
    check("s1_req", 32'(req), 32'd1);
    check("s1_id", 32'(id), 32'd2);
    ack_tick();
    check("s1_req_drop", 32'(req), 32'd0);
    cfg_read(2'd1, rd);
    check("s1_pending", rd, 32'd0);
    cfg_read(2'd3, rd);
    check("s1_status_svc", rd & 32'h3, 32'd2);
    cfg_write(2'd2, 32'd0);
    cfg_read(2'd3, rd);
    check("s1_status_idle", rd & 32'h3, 32'd0);

    // Two simultaneous sources, then 0 and 1 together (pointer wraps in round-robin).
    pulse(4'b1010);
    check("s2_first", 32'(id), 32'd1);
    ack_tick();
    cfg_write(2'd2, 32'd0);
    tick();
    check("s2_second_req", 32'(req), 32'd1);
    check("s2_second", 32'(id), 32'd3);
    ack_tick();
    cfg_write(2'd2, 32'd0);
    pulse(4'b0011);
    check("s2_third", 32'(id), 32'd0);
    ack_tick();
    cfg_write(2'd2, 32'd0);
    tick();
    check("s2_fourth", 32'(id), 32'd1);
    ack_tick();
    cfg_write(2'd2, 32'd0);

    // Masked-out source stays pending; unmasking raises the request.
    cfg_write(2'd0, 32'h0);
    pulse(4'b0001);
    cfg_read(2'd1, rd);
    check("s3_pending", rd, 32'd1);
    check("s3_no_req", 32'(req), 32'd0);
    cfg_write(2'd0, 32'h1);
    check("s3_req_wait", 32'(req), 32'd0);
    tick();
    check("s3_req", 32'(req), 32'd1);
    check("s3_id", 32'(id), 32'd0);
    ack_tick();
    cfg_write(2'd2, 32'd0);
    enw = 1'b1; enr = 1'b1; addr = 2'd0; dataw = 32'h5;
    tick();
    enw = 1'b0; enr = 1'b0;
    check("s3_rw_old", datar, 32'h1);
    cfg_read(2'd0, rd);
    check("s3_rw_new", rd, 32'h5);

    // Mask drop and stray EOI while requesting do not withdraw the request.
    cfg_write(2'd0, 32'hF);
    pulse(4'b0010);
    check("s4_id", 32'(id), 32'd1);
    cfg_write(2'd0, 32'h0);
    check("s4_req_hold", 32'(req), 32'd1);
    check("s4_id_hold", 32'(id), 32'd1);
    cfg_write(2'd2, 32'd0);
    tick();
    check("s4_req_eoi", 32'(req), 32'd1);
    ack_tick();
    check("s4_req_drop", 32'(req), 32'd0);
    cfg_read(2'd3, rd);
    check("s4_status", rd & 32'h3, 32'd2);
    cfg_write(2'd2, 32'd0);
    ack_tick();
    cfg_read(2'd3, rd);
    check("s4_stray_ack", rd & 32'h3, 32'd0);

    // W1C coinciding with a new rising edge: set wins.
    pulse(4'b0100);
    irq = 4'b0100; enw = 1'b1; addr = 2'd1; dataw = 32'h4;
    tick();
    enw = 1'b0; irq = '0;
    cfg_read(2'd1, rd);
    check("s5_set_wins", rd, 32'h4);

    // Reset in SERVICE with two pending.
    cfg_write(2'd0, 32'hF);
    tick();
    ack_tick();
    pulse(4'b0011);
    cfg_read(2'd1, rd);
    check("s6_pending", rd, 32'h3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("s6_req", 32'(req), 32'd0);
    check("s6_id", 32'(id), 32'd0);
    cfg_read(2'd3, rd);
    check("s6_status", rd, 32'd0);
    cfg_read(2'd1, rd);
    check("s6_pend", rd, 32'd0);

    // Random traffic against the model.
    for (int n = 0; n < 600; n++) begin
      irq   = ($urandom_range(0, 3) == 0) ? NUM_SRC'($urandom) : irq;
      enw   = ($urandom_range(0, 5) == 0);
      enr   = ($urandom_range(0, 2) == 0);
      addr  = 2'($urandom);
      dataw = $urandom;
      ack   = ($urandom_range(0, 2) == 0);
      rst   = ($urandom_range(0, 149) == 0);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
